// File: rtl/ce_axis_tx_arb_pkg.sv
// Shared types and helpers for the copy-engine stream arbiters: state encoding
// and the wrap-around round-robin index search.
package ce_arb_pkg;

    localparam int CE_ARB_MAX_REQ = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Unused upper request bits must be zero, so an 8-way wrap equals a NUM_REQ-way wrap.
    function automatic logic [2:0] rr_pick(input logic [CE_ARB_MAX_REQ-1:0] valid,
                                           input logic [2:0]                ptr);
        logic [2:0] idx;
        logic [2:0] cand;
        logic       found;
        idx   = 3'd0;
        found = 1'b0;
        for (int k = 0; k < CE_ARB_MAX_REQ; k++) begin
            cand = ptr + 3'(k);
            if (!found && valid[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/ce_axis_tx_arb_picker.sv
// Combinational round-robin index select, reusable by other copy-engine arbiters.
module ce_rr_picker
    import ce_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [CE_ARB_MAX_REQ-1:0] valid_ext_s;
    logic [2:0]                ptr_ext_s;
    logic [2:0]                pick_s;

    // Widen request vector and pointer to the helper's fixed width.
    always_comb begin
        valid_ext_s              = '0;
        valid_ext_s[NUM_REQ-1:0] = valid;
        ptr_ext_s                = 3'(ptr);
        pick_s                   = rr_pick(valid_ext_s, ptr_ext_s);
    end

    assign idx = IDX_W'(pick_s);
    assign any = |valid;

endmodule

// File: rtl/ce_axis_tx_arb.sv
// Packet-level round-robin arbiter onto the PCIe SS TX AXI-Stream.
// Optional per-requester packet counters: define CE_TX_ARB_PKT_CNT_EN.
module ce_axis_tx_arb
    import ce_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 512,
    parameter int USER_WIDTH = 10,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int REQ_IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               s_tvalid,
    output logic [NUM_REQ-1:0]               s_tready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    s_tdata,
    input  logic [NUM_REQ*KEEP_WIDTH-1:0]    s_tkeep,
    input  logic [NUM_REQ*USER_WIDTH-1:0]    s_tuser,
    input  logic [NUM_REQ-1:0]               s_tlast,
    output logic                             m_tvalid,
    input  logic                             m_tready,
    output logic [DATA_WIDTH-1:0]            m_tdata,
    output logic [KEEP_WIDTH-1:0]            m_tkeep,
    output logic [USER_WIDTH-1:0]            m_tuser,
    output logic                             m_tlast,
`ifdef CE_TX_ARB_PKT_CNT_EN
    output logic [NUM_REQ*32-1:0]            pkt_cnt,
`endif
    output logic [REQ_IDX_W-1:0]             gnt_idx,
    output logic                             busy
);

    arb_state_t           state_r, state_nxt_s;
    logic [REQ_IDX_W-1:0] gnt_r, gnt_nxt_s;
    logic [REQ_IDX_W-1:0] rr_ptr_r, rr_ptr_nxt_s;
    logic [REQ_IDX_W-1:0] pick_s;
    logic                 pick_any_s;
    logic                 last_hs_s;

    ce_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (REQ_IDX_W)
    ) u_picker (
        .valid (s_tvalid),
        .ptr   (rr_ptr_r),
        .idx   (pick_s),
        .any   (pick_any_s)
    );

    // Arbiter state, held grant and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            gnt_r    <= '0;
            rr_ptr_r <= '0;
        end else begin
            state_r  <= state_nxt_s;
            gnt_r    <= gnt_nxt_s;
            rr_ptr_r <= rr_ptr_nxt_s;
        end
    end

    // Next-state logic and the zero-latency pass-through of the granted stream.
    always_comb begin
        state_nxt_s  = state_r;
        gnt_nxt_s    = gnt_r;
        rr_ptr_nxt_s = rr_ptr_r;
        last_hs_s    = 1'b0;
        s_tready     = '0;
        m_tvalid     = 1'b0;
        m_tdata      = '0;
        m_tkeep      = '0;
        m_tuser      = '0;
        m_tlast      = 1'b0;
        case (state_r)
            IDLE: begin
                if (pick_any_s) begin
                    gnt_nxt_s   = pick_s;
                    state_nxt_s = BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                m_tvalid        = s_tvalid[gnt_r];
                m_tdata         = s_tdata[gnt_r*DATA_WIDTH +: DATA_WIDTH];
                m_tkeep         = s_tkeep[gnt_r*KEEP_WIDTH +: KEEP_WIDTH];
                m_tuser         = s_tuser[gnt_r*USER_WIDTH +: USER_WIDTH];
                m_tlast         = s_tlast[gnt_r];
                s_tready[gnt_r] = m_tready;
                last_hs_s       = m_tvalid & m_tready & m_tlast;
                // Grant is released only on the tlast handshake, so TLPs never interleave.
                if (last_hs_s) begin
                    state_nxt_s  = IDLE;
                    rr_ptr_nxt_s = (gnt_r == REQ_IDX_W'(NUM_REQ - 1)) ? '0
                                                                       : gnt_r + REQ_IDX_W'(1);
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    assign gnt_idx = gnt_r;
    assign busy    = (state_r == BUSY);

`ifdef CE_TX_ARB_PKT_CNT_EN
    logic [NUM_REQ*32-1:0] cnt_r;

    // Per-requester completed-packet counters for the debug CSRs; wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (last_hs_s && (gnt_r == REQ_IDX_W'(i))) begin
                    cnt_r[i*32 +: 32] <= cnt_r[i*32 +: 32] + 32'd1;
                end
            end
        end
    end

    assign pkt_cnt = cnt_r;
`endif

endmodule

// File: tb/tb_ce_axis_tx_arb.sv
// Scoreboard bench for ce_axis_tx_arb (3 requesters, 32-bit data).
module tb_ce_axis_tx_arb;

    localparam int NREQ = 3;
    localparam int DW   = 32;
    localparam int KW   = 4;
    localparam int UW   = 10;
    localparam int IW   = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   s_tvalid, s_tready, s_tlast;
    logic [NREQ*DW-1:0] s_tdata;
    logic [NREQ*KW-1:0] s_tkeep;
    logic [NREQ*UW-1:0] s_tuser;
    logic              m_tvalid, m_tready, m_tlast;
    logic [DW-1:0]     m_tdata;
    logic [KW-1:0]     m_tkeep;
    logic [UW-1:0]     m_tuser;
    logic [IW-1:0]     gnt_idx;
    logic              busy;
`ifdef CE_TX_ARB_PKT_CNT_EN
    logic [NREQ*32-1:0] pkt_cnt;
    logic [NREQ*32-1:0] cnt_tmp;
`endif

    always #5 clk = ~clk;

    ce_axis_tx_arb #(
        .NUM_REQ(NREQ), .DATA_WIDTH(DW), .USER_WIDTH(UW), .KEEP_WIDTH(KW), .REQ_IDX_W(IW)
    ) dut (
        .clk(clk), .rst(rst),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .s_tkeep(s_tkeep), .s_tuser(s_tuser), .s_tlast(s_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .m_tkeep(m_tkeep), .m_tuser(m_tuser), .m_tlast(m_tlast),
`ifdef CE_TX_ARB_PKT_CNT_EN
        .pkt_cnt(pkt_cnt),
`endif
        .gnt_idx(gnt_idx), .busy(busy)
    );

    typedef struct packed {
        logic [1:0]    req;
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    beat_t src_q [NREQ][$];
    beat_t exp_q [$];
    beat_t mon_e;
    logic [NREQ-1:0] drv_hs;
    int n_checks = 0;
    int n_pass   = 0;
    int beat_cnt = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic beat_t mk_beat(input int r, input int b, input int n, input logic [7:0] tag);
        beat_t x;
        x.req  = 2'(r);
        x.data = {tag, 8'(r), 8'(b), 8'hA0 + 8'(b)};
        x.keep = (b == n - 1) ? 4'h3 : 4'hF;
        x.user = {2'(r), 8'(b)} + 10'(tag);
        x.last = (b == n - 1);
        return x;
    endfunction

    task automatic push_src(input int r, input int n, input logic [7:0] tag);
        for (int b = 0; b < n; b++) src_q[r].push_back(mk_beat(r, b, n, tag));
    endtask

    task automatic push_exp(input int r, input int n, input logic [7:0] tag);
        for (int b = 0; b < n; b++) exp_q.push_back(mk_beat(r, b, n, tag));
    endtask

    task automatic send(input int r, input int n, input logic [7:0] tag);
        push_src(r, n, tag);
        push_exp(r, n, tag);
    endtask

    task automatic drive_sources();
        for (int i = 0; i < NREQ; i++) begin
            if (src_q[i].size() > 0) begin
                s_tvalid[i]            = 1'b1;
                s_tdata[i*DW +: DW]    = src_q[i][0].data;
                s_tkeep[i*KW +: KW]    = src_q[i][0].keep;
                s_tuser[i*UW +: UW]    = src_q[i][0].user;
                s_tlast[i]             = src_q[i][0].last;
            end else begin
                s_tvalid[i]            = 1'b0;
                s_tdata[i*DW +: DW]    = '0;
                s_tkeep[i*KW +: KW]    = '0;
                s_tuser[i*UW +: UW]    = '0;
                s_tlast[i]             = 1'b0;
            end
        end
    endtask

    // Source model: handshakes sampled mid-cycle, queues advanced just after the edge.
    always begin
        @(negedge clk);
        drv_hs = s_tvalid & s_tready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++)
            if (drv_hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        drive_sources();
    end

    // Output monitor: every accepted beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (m_tvalid && m_tready) begin
            beat_cnt++;
            if (exp_q.size() == 0) begin
                check_val("extra_beat", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("gnt",  64'(gnt_idx), 64'(mon_e.req));
                check_val("data", 64'(m_tdata), 64'(mon_e.data));
                check_val("keep", 64'(m_tkeep), 64'(mon_e.keep));
                check_val("user", 64'(m_tuser), 64'(mon_e.user));
                check_val("last", 64'(m_tlast), 64'(mon_e.last));
            end
        end
    end

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0 && !busy) break;
            @(negedge clk); #1;
        end
        check_val(tag, 64'(exp_q.size() == 0 && !busy), 64'd1);
    endtask

    task automatic wait_busy(input string tag);
        for (int i = 0; i < 100; i++) begin
            if (busy) break;
            @(negedge clk); #1;
        end
        check_val(tag, 64'(busy), 64'd1);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst      = 1'b1;
        m_tready = 1'b1;
        repeat (2) @(posedge clk);
        for (int i = 0; i < NREQ; i++) src_q[i].delete();
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int           start;
        logic [3:0]   pat;
        logic [DW-1:0] prev;
        m_tready = 1'b1;
        s_tvalid = '0; s_tlast = '0; s_tdata = '0; s_tkeep = '0; s_tuser = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check_val("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        check_val("rst_s_tready", 64'(s_tready), 64'd0);
        check_val("rst_busy",     64'(busy),     64'd0);
        check_val("rst_gnt",      64'(gnt_idx),  64'd0);
        check_val("rst_rr_ptr",   64'(dut.rr_ptr_r), 64'd0);
        rst = 1'b0;

        // 3-beat packet from requester 0: one-cycle bubble, then back-to-back beats
        @(negedge clk); #1;
        start = beat_cnt;
        send(0, 3, 8'h00);
        @(negedge clk); #1;
        check_val("s1_src_valid", 64'(s_tvalid[0]), 64'd1);
        check_val("s1_bubble",    64'(m_tvalid),    64'd0);
        check_val("s1_no_ready",  64'(s_tready),    64'd0);
        @(negedge clk); #1;
        check_val("s1_first_valid", 64'(m_tvalid), 64'd1);
        check_val("s1_first_data",  64'(m_tdata),  64'h0000_00A0);
        repeat (3) begin @(negedge clk); #1; end
        check_val("s1_busy_done", 64'(busy),            64'd0);
        check_val("s1_beats",     64'(beat_cnt - start), 64'd3);
        check_val("s1_rr_ptr",    64'(dut.rr_ptr_r),     64'd1);
        check_val("s1_idle_data", 64'(m_tdata),          64'd0);

        // Two requesters with continuous 2-beat packets alternate 0,1,0,1
        reset_dut();
        push_src(0, 2, 8'h11); push_src(0, 2, 8'h12);
        push_src(1, 2, 8'h11); push_src(1, 2, 8'h12);
        push_exp(0, 2, 8'h11); push_exp(1, 2, 8'h11);
        push_exp(0, 2, 8'h12); push_exp(1, 2, 8'h12);
        wait_drain("s2_drain");

        // Backpressure 1,0,0,1 while requester 1 waits (pointer is 2, so 0 wins)
        send(0, 4, 8'h21);
        send(1, 2, 8'h22);
        wait_busy("s3_busy");
        check_val("s3_gnt", 64'(gnt_idx), 64'd0);
        pat  = 4'b1001;
        prev = m_tdata;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            m_tready = pat[k];
            @(negedge clk); #1;
            check_val("s3_rdy_gnt",   64'(s_tready[0]),   64'(m_tready));
            check_val("s3_rdy_other", 64'(s_tready[2:1]), 64'd0);
            if (k > 0 && pat[k-1] == 1'b0) check_val("s3_hold", 64'(m_tdata), 64'(prev));
            prev = m_tdata;
        end
        m_tready = 1'b1;
        wait_drain("s3_drain");

        // Wrap: requester 2 alone, then 2 and 0 together -> 0 first after wrap
        reset_dut();
        send(2, 2, 8'h31);
        wait_drain("s4_drain_a");
        check_val("s4_rr_wrap", 64'(dut.rr_ptr_r), 64'd0);
        push_src(2, 2, 8'h32); push_src(0, 2, 8'h32);
        push_exp(0, 2, 8'h32); push_exp(2, 2, 8'h32);
        wait_drain("s4_drain_b");

        // Async reset during beat 2 of a 6-beat packet
        reset_dut();
        start = beat_cnt;
        push_src(0, 6, 8'h41); push_exp(0, 6, 8'h41);
        push_src(1, 1, 8'h41);
        for (int i = 0; i < 100; i++) begin
            if (beat_cnt >= start + 2) break;
            @(negedge clk); #1;
        end
        check_val("s5_mid_valid", 64'(m_tvalid && busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        check_val("s5_rst_m_tvalid", 64'(m_tvalid),      64'd0);
        check_val("s5_rst_s_tready", 64'(s_tready),      64'd0);
        check_val("s5_rst_busy",     64'(busy),          64'd0);
        check_val("s5_rst_rr_ptr",   64'(dut.rr_ptr_r),  64'd0);
        repeat (2) @(posedge clk);
        for (int i = 0; i < NREQ; i++) src_q[i].delete();
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        push_src(1, 1, 8'h42); push_src(0, 1, 8'h42);
        push_exp(0, 1, 8'h42); push_exp(1, 1, 8'h42);
        wait_drain("s5_drain");

`ifdef CE_TX_ARB_PKT_CNT_EN
        reset_dut();
        for (int p = 0; p < 5; p++) send(1, 2, 8'(8'h50 + 8'(p)));
        wait_drain("s6_drain_a");
        check_val("s6_cnt1", 64'(pkt_cnt[63:32]), 64'd5);
        check_val("s6_cnt0", 64'(pkt_cnt[31:0]),  64'd0);
        cnt_tmp        = dut.cnt_r;
        cnt_tmp[31:0]  = 32'hFFFF_FFFF;
        force dut.cnt_r = cnt_tmp;
        @(posedge clk); #1;
        release dut.cnt_r;
        send(0, 1, 8'h5F);
        wait_drain("s6_drain_b");
        check_val("s6_cnt0_wrap", 64'(pkt_cnt[31:0]),  64'd0);
        check_val("s6_cnt1_keep", 64'(pkt_cnt[63:32]), 64'd5);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
